// File: rtl/axi_lite_arbiter.sv
// Round-robin share of one AXI-Lite slave among NUM_MASTER masters; reads and writes arbitrate independently.
// Slave sees a request 1 cycle after master valid; one transaction per direction in flight, ready/valid passed through to the grantee.
module axi_lite_arbiter #(
  parameter int NUM_MASTER = 2,
  parameter int ADDR_WIDTH = 48,
  parameter int DATA_WIDTH = 64,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int IDX_WIDTH  = $clog2(NUM_MASTER)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTER-1:0]            m_aw_valid,
  output logic [NUM_MASTER-1:0]            m_aw_ready,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_aw_addr,
  input  logic [NUM_MASTER*3-1:0]          m_aw_prot,
  input  logic [NUM_MASTER-1:0]            m_w_valid,
  output logic [NUM_MASTER-1:0]            m_w_ready,
  input  logic [NUM_MASTER*DATA_WIDTH-1:0] m_w_data,
  input  logic [NUM_MASTER*STRB_WIDTH-1:0] m_w_strb,
  output logic [NUM_MASTER-1:0]            m_b_valid,
  input  logic [NUM_MASTER-1:0]            m_b_ready,
  output logic [NUM_MASTER*2-1:0]          m_b_resp,
  input  logic [NUM_MASTER-1:0]            m_ar_valid,
  output logic [NUM_MASTER-1:0]            m_ar_ready,
  input  logic [NUM_MASTER*ADDR_WIDTH-1:0] m_ar_addr,
  input  logic [NUM_MASTER*3-1:0]          m_ar_prot,
  output logic [NUM_MASTER-1:0]            m_r_valid,
  input  logic [NUM_MASTER-1:0]            m_r_ready,
  output logic [NUM_MASTER*DATA_WIDTH-1:0] m_r_data,
  output logic [NUM_MASTER*2-1:0]          m_r_resp,
  output logic                             s_aw_valid,
  input  logic                             s_aw_ready,
  output logic [ADDR_WIDTH-1:0]            s_aw_addr,
  output logic [2:0]                       s_aw_prot,
  output logic                             s_w_valid,
  input  logic                             s_w_ready,
  output logic [DATA_WIDTH-1:0]            s_w_data,
  output logic [STRB_WIDTH-1:0]            s_w_strb,
  input  logic                             s_b_valid,
  output logic                             s_b_ready,
  input  logic [1:0]                       s_b_resp,
  output logic                             s_ar_valid,
  input  logic                             s_ar_ready,
  output logic [ADDR_WIDTH-1:0]            s_ar_addr,
  output logic [2:0]                       s_ar_prot,
  input  logic                             s_r_valid,
  output logic                             s_r_ready,
  input  logic [DATA_WIDTH-1:0]            s_r_data,
  input  logic [1:0]                       s_r_resp
);

  localparam logic [1:0] W_IDLE = 2'd0, W_ADDR = 2'd1, W_RESP = 2'd2;
  localparam logic [1:0] R_IDLE = 2'd0, R_ADDR = 2'd1, R_RESP = 2'd2;

  logic [1:0]           wstate, rstate;
  logic [IDX_WIDTH-1:0] wgnt, wptr, rgnt, rptr;
  logic                 aw_done, w_done;
  logic                 aw_hs, w_hs, b_hs, ar_hs, r_hs;

  logic [ADDR_WIDTH-1:0] aw_addr_a [NUM_MASTER];
  logic [2:0]            aw_prot_a [NUM_MASTER];
  logic [DATA_WIDTH-1:0] w_data_a  [NUM_MASTER];
  logic [STRB_WIDTH-1:0] w_strb_a  [NUM_MASTER];
  logic [ADDR_WIDTH-1:0] ar_addr_a [NUM_MASTER];
  logic [2:0]            ar_prot_a [NUM_MASTER];

  for (genvar i = 0; i < NUM_MASTER; i++) begin : g_lane
    assign aw_addr_a[i] = m_aw_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign aw_prot_a[i] = m_aw_prot[i*3 +: 3];
    assign w_data_a[i]  = m_w_data[i*DATA_WIDTH +: DATA_WIDTH];
    assign w_strb_a[i]  = m_w_strb[i*STRB_WIDTH +: STRB_WIDTH];
    assign ar_addr_a[i] = m_ar_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    assign ar_prot_a[i] = m_ar_prot[i*3 +: 3];
  end

  // Scan downward so the requester closest to ptr (in wrap order) is the last to overwrite sel.
  function automatic logic [IDX_WIDTH-1:0] rr_pick(input logic [NUM_MASTER-1:0] req,
                                                   input logic [IDX_WIDTH-1:0]  ptr);
    logic [IDX_WIDTH-1:0] sel;
    logic [IDX_WIDTH-1:0] idx;
    sel = ptr;
    for (int k = NUM_MASTER - 1; k >= 0; k--) begin
      idx = IDX_WIDTH'((int'(ptr) + k) % NUM_MASTER);
      if (req[idx]) sel = idx;
    end
    return sel;
  endfunction

  function automatic logic [IDX_WIDTH-1:0] next_idx(input logic [IDX_WIDTH-1:0] g);
    return (int'(g) == NUM_MASTER - 1) ? '0 : g + 1'b1;
  endfunction

  always_comb begin
    s_aw_valid = 1'b0;
    s_aw_addr  = '0;
    s_aw_prot  = '0;
    m_aw_ready = '0;
    s_w_valid  = 1'b0;
    s_w_data   = '0;
    s_w_strb   = '0;
    m_w_ready  = '0;
    m_b_valid  = '0;
    s_b_ready  = 1'b0;
    m_b_resp   = {NUM_MASTER{s_b_resp}};
    if (wstate == W_ADDR) begin
      s_aw_valid       = m_aw_valid[wgnt] & ~aw_done;
      s_aw_addr        = aw_addr_a[wgnt];
      s_aw_prot        = aw_prot_a[wgnt];
      m_aw_ready[wgnt] = s_aw_ready & ~aw_done;
      s_w_valid        = m_w_valid[wgnt] & ~w_done;
      s_w_data         = w_data_a[wgnt];
      s_w_strb         = w_strb_a[wgnt];
      m_w_ready[wgnt]  = s_w_ready & ~w_done;
    end
    if (wstate == W_RESP) begin
      m_b_valid[wgnt] = s_b_valid;
      s_b_ready       = m_b_ready[wgnt];
    end
  end

  always_comb begin
    s_ar_valid = 1'b0;
    s_ar_addr  = '0;
    s_ar_prot  = '0;
    m_ar_ready = '0;
    m_r_valid  = '0;
    s_r_ready  = 1'b0;
    m_r_data   = {NUM_MASTER{s_r_data}};
    m_r_resp   = {NUM_MASTER{s_r_resp}};
    if (rstate == R_ADDR) begin
      s_ar_valid       = m_ar_valid[rgnt];
      s_ar_addr        = ar_addr_a[rgnt];
      s_ar_prot        = ar_prot_a[rgnt];
      m_ar_ready[rgnt] = s_ar_ready;
    end
    if (rstate == R_RESP) begin
      m_r_valid[rgnt] = s_r_valid;
      s_r_ready       = m_r_ready[rgnt];
    end
  end

  assign aw_hs = s_aw_valid & s_aw_ready;
  assign w_hs  = s_w_valid & s_w_ready;
  assign b_hs  = s_b_valid & s_b_ready;
  assign ar_hs = s_ar_valid & s_ar_ready;
  assign r_hs  = s_r_valid & s_r_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      wstate  <= W_IDLE;
      wgnt    <= '0;
      wptr    <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      case (wstate)
        W_IDLE: if (|m_aw_valid) begin
          wgnt   <= rr_pick(m_aw_valid, wptr);
          wstate <= W_ADDR;
        end
        W_ADDR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if ((aw_done | aw_hs) & (w_done | w_hs)) wstate <= W_RESP;
        end
        W_RESP: if (b_hs) begin
          wptr    <= next_idx(wgnt);
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          wstate  <= W_IDLE;
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rstate <= R_IDLE;
      rgnt   <= '0;
      rptr   <= '0;
    end else begin
      case (rstate)
        R_IDLE: if (|m_ar_valid) begin
          rgnt   <= rr_pick(m_ar_valid, rptr);
          rstate <= R_ADDR;
        end
        R_ADDR: if (ar_hs) rstate <= R_RESP;
        R_RESP: if (r_hs) begin
          rptr   <= next_idx(rgnt);
          rstate <= R_IDLE;
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Bench for axi_lite_arbiter: directed scenarios plus randomized concurrent read/write rounds
// checked against a request-set / round-robin-pointer model.
module tb_axi_lite_arbiter;

  localparam int NM = 2;
  localparam int AW = 48;
  localparam int DW = 64;
  localparam int SW = DW / 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NM-1:0]     m_aw_valid = '0, m_aw_ready;
  logic [NM*AW-1:0]  m_aw_addr = '0;
  logic [NM*3-1:0]   m_aw_prot = '0;
  logic [NM-1:0]     m_w_valid = '0, m_w_ready;
  logic [NM*DW-1:0]  m_w_data = '0;
  logic [NM*SW-1:0]  m_w_strb = '0;
  logic [NM-1:0]     m_b_valid, m_b_ready = '0;
  logic [NM*2-1:0]   m_b_resp;
  logic [NM-1:0]     m_ar_valid = '0, m_ar_ready;
  logic [NM*AW-1:0]  m_ar_addr = '0;
  logic [NM*3-1:0]   m_ar_prot = '0;
  logic [NM-1:0]     m_r_valid, m_r_ready = '0;
  logic [NM*DW-1:0]  m_r_data;
  logic [NM*2-1:0]   m_r_resp;
  logic              s_aw_valid, s_aw_ready = 1'b0;
  logic [AW-1:0]     s_aw_addr;
  logic [2:0]        s_aw_prot;
  logic              s_w_valid, s_w_ready = 1'b0;
  logic [DW-1:0]     s_w_data;
  logic [SW-1:0]     s_w_strb;
  logic              s_b_valid = 1'b0, s_b_ready;
  logic [1:0]        s_b_resp = '0;
  logic              s_ar_valid, s_ar_ready = 1'b0;
  logic [AW-1:0]     s_ar_addr;
  logic [2:0]        s_ar_prot;
  logic              s_r_valid = 1'b0, s_r_ready;
  logic [DW-1:0]     s_r_data = '0;
  logic [1:0]        s_r_resp = '0;

  axi_lite_arbiter #(.NUM_MASTER(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready), .m_aw_addr(m_aw_addr), .m_aw_prot(m_aw_prot),
    .m_w_valid(m_w_valid), .m_w_ready(m_w_ready), .m_w_data(m_w_data), .m_w_strb(m_w_strb),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_resp(m_b_resp),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr), .m_ar_prot(m_ar_prot),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_data(m_r_data), .m_r_resp(m_r_resp),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_addr(s_aw_addr), .s_aw_prot(s_aw_prot),
    .s_w_valid(s_w_valid), .s_w_ready(s_w_ready), .s_w_data(s_w_data), .s_w_strb(s_w_strb),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_resp(s_b_resp),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_addr(s_ar_addr), .s_ar_prot(s_ar_prot),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_data(s_r_data), .s_r_resp(s_r_resp)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding request sets, next-priority pointers, per-master payloads.
  logic [NM-1:0] wpend = '0, rpend = '0;
  int            wptr_m = 0, rptr_m = 0;
  logic [AW-1:0] waddr [NM];
  logic [2:0]    wprot [NM];
  logic [DW-1:0] wdata [NM];
  logic [SW-1:0] wstrb [NM];
  logic [AW-1:0] raddr [NM];
  logic [2:0]    rprot [NM];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic int pick(input logic [NM-1:0] req, input int ptr);
    for (int k = 0; k < NM; k++)
      if (req[(ptr + k) % NM]) return (ptr + k) % NM;
    return -1;
  endfunction

  function automatic logic [NM-1:0] oh(input int i);
    return NM'(1) << i;
  endfunction

  function automatic logic [63:0] ctl_outs();
    return 64'({s_aw_valid, s_w_valid, s_b_ready, s_ar_valid, s_r_ready,
                m_aw_ready, m_w_ready, m_b_valid, m_ar_ready, m_r_valid});
  endfunction

  task automatic wprep(input int i);
    waddr[i] = AW'({$urandom, $urandom});
    wprot[i] = 3'($urandom);
    wdata[i] = {$urandom, $urandom};
    wstrb[i] = SW'($urandom);
    m_aw_addr[i*AW +: AW] = waddr[i];
    m_aw_prot[i*3 +: 3]   = wprot[i];
    m_w_data[i*DW +: DW]  = wdata[i];
    m_w_strb[i*SW +: SW]  = wstrb[i];
  endtask

  task automatic rprep(input int i);
    raddr[i] = AW'({$urandom, $urandom});
    rprot[i] = 3'($urandom);
    m_ar_addr[i*AW +: AW] = raddr[i];
    m_ar_prot[i*3 +: 3]   = rprot[i];
  endtask

  // Entered and left mid-cycle with the write side idle; awd/wd/bd are slave/master ready delays.
  task automatic do_write(input logic [NM-1:0] add, input int awd, input int wd, input int bd);
    int win, n;
    bit ad, dd;
    logic [1:0] resp;
    if ((wpend | add) == '0) add[$urandom_range(0, NM-1)] = 1'b1;
    // A master already showing W has had its payload prepared ahead of its AW.
    for (int i = 0; i < NM; i++)
      if (add[i] && !wpend[i] && !m_w_valid[i]) wprep(i);
    wpend = wpend | add;
    m_aw_valid = wpend;
    m_w_valid  = m_w_valid | wpend;
    win = pick(wpend, wptr_m);
    settle();
    chk("w_idle_aw_valid", 64'(s_aw_valid), 0);
    cyc();
    ad = 0; dd = 0; n = 0;
    while (!(ad && dd)) begin
      s_aw_ready = (n >= awd);
      s_w_ready  = (n >= wd);
      settle();
      chk("s_aw_valid", 64'(s_aw_valid), 64'(!ad));
      chk("m_aw_ready", 64'(m_aw_ready), 64'((s_aw_ready && !ad) ? oh(win) : '0));
      chk("s_w_valid", 64'(s_w_valid), 64'(!dd));
      chk("m_w_ready", 64'(m_w_ready), 64'((s_w_ready && !dd) ? oh(win) : '0));
      if (!ad) begin
        chk("s_aw_addr", 64'(s_aw_addr), 64'(waddr[win]));
        chk("s_aw_prot", 64'(s_aw_prot), 64'(wprot[win]));
      end
      if (!dd) begin
        chk("s_w_data", s_w_data, wdata[win]);
        chk("s_w_strb", 64'(s_w_strb), 64'(wstrb[win]));
      end
      if (s_aw_ready) ad = 1;
      if (s_w_ready)  dd = 1;
      cyc();
      n++;
      if (ad) m_aw_valid[win] = 1'b0;
      if (dd) m_w_valid[win]  = 1'b0;
    end
    s_aw_ready = 1'b0;
    s_w_ready  = 1'b0;
    wpend[win] = 1'b0;
    resp = 2'($urandom);
    s_b_resp  = resp;
    s_b_valid = 1'b1;
    for (int k = 0; k <= bd; k++) begin
      m_b_ready = NM'($urandom);
      m_b_ready[win] = (k == bd);
      settle();
      chk("m_b_valid", 64'(m_b_valid), 64'(oh(win)));
      chk("m_b_resp", 64'(m_b_resp[win*2 +: 2]), 64'(resp));
      chk("s_b_ready", 64'(s_b_ready), 64'(k == bd));
      chk("aw_held_in_resp", 64'(m_aw_ready), 0);
      cyc();
    end
    s_b_valid = 1'b0;
    m_b_ready = '0;
    wptr_m = (win + 1) % NM;
    settle();
    chk("w_return_idle", 64'({s_aw_valid, s_w_valid, s_b_ready, m_aw_ready, m_w_ready, m_b_valid}), 0);
    m_aw_valid = '0;
    m_w_valid  = '0;
  endtask

  task automatic do_read(input logic [NM-1:0] add, input int ard, input int rd);
    int win;
    logic [DW-1:0] data;
    logic [1:0] resp;
    if ((rpend | add) == '0) add[$urandom_range(0, NM-1)] = 1'b1;
    for (int i = 0; i < NM; i++)
      if (add[i] && !rpend[i]) rprep(i);
    rpend = rpend | add;
    m_ar_valid = rpend;
    win = pick(rpend, rptr_m);
    settle();
    chk("r_idle_ar_valid", 64'(s_ar_valid), 0);
    cyc();
    for (int k = 0; k <= ard; k++) begin
      s_ar_ready = (k == ard);
      settle();
      chk("s_ar_valid", 64'(s_ar_valid), 1);
      chk("s_ar_addr", 64'(s_ar_addr), 64'(raddr[win]));
      chk("s_ar_prot", 64'(s_ar_prot), 64'(rprot[win]));
      chk("m_ar_ready", 64'(m_ar_ready), 64'((k == ard) ? oh(win) : '0));
      cyc();
    end
    m_ar_valid[win] = 1'b0;
    rpend[win] = 1'b0;
    s_ar_ready = 1'b0;
    data = {$urandom, $urandom};
    resp = 2'($urandom);
    s_r_data  = data;
    s_r_resp  = resp;
    s_r_valid = 1'b1;
    for (int k = 0; k <= rd; k++) begin
      m_r_ready = NM'($urandom);
      m_r_ready[win] = (k == rd);
      settle();
      chk("m_r_valid", 64'(m_r_valid), 64'(oh(win)));
      chk("m_r_data", m_r_data[win*DW +: DW], data);
      chk("m_r_resp", 64'(m_r_resp[win*2 +: 2]), 64'(resp));
      chk("s_r_ready", 64'(s_r_ready), 64'(k == rd));
      chk("ar_held_in_resp", 64'(m_ar_ready), 0);
      cyc();
    end
    s_r_valid = 1'b0;
    m_r_ready = '0;
    rptr_m = (win + 1) % NM;
    settle();
    chk("r_return_idle", 64'({s_ar_valid, s_r_ready, m_ar_ready, m_r_valid}), 0);
    m_ar_valid = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    cyc();
    cyc();
    settle();
    chk("reset_outputs", ctl_outs(), 0);
    chk("reset_wptr", 64'(dut.wptr), 0);
    chk("reset_rptr", 64'(dut.rptr), 0);
    rst = 1'b0;
    cyc();

    // B back-pressure on M0 while M1 waits, then M1 drains
    do_write(2'b11, 0, 0, 5);
    do_write(2'b00, 1, 0, 0);

    // Single write from M0
    do_write(2'b01, 0, 0, 0);
    chk("wptr_after_m0", 64'(dut.wptr), 1);

    // Read contention: grants must go 0,1,0,1
    do_read(2'b11, 0, 0);
    do_read(2'b01, 0, 0);
    do_read(2'b10, 1, 0);
    do_read(2'b00, 0, 2);

    // W from M1 two cycles ahead of its AW
    wprep(1);
    m_w_valid[1] = 1'b1;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("w_early_blocked", 64'({s_w_valid, m_w_ready}), 0);
      cyc();
    end
    do_write(2'b10, 3, 0, 0);

    // Concurrent M0 write and M1 read
    fork
      do_write(2'b01, 1, 2, 1);
      do_read(2'b10, 2, 1);
    join

    // Randomized concurrent rounds
    for (int r = 0; r < 30; r++) begin
      fork
        do_write(NM'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        do_read(NM'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      join
    end
    while (wpend != '0) do_write('0, 0, 0, 0);
    while (rpend != '0) do_read('0, 0, 0);

    // Reset in W_ADDR after AW handshake, before W
    do_write(2'b01, 0, 0, 0);
    wprep(0);
    m_aw_valid = 2'b01;
    m_w_valid  = 2'b01;
    cyc();
    s_aw_ready = 1'b1;
    settle();
    chk("rst_pre_aw_ready", 64'(m_aw_ready), 64'(2'b01));
    cyc();
    s_aw_ready = 1'b0;
    m_aw_valid = '0;
    m_w_valid  = '0;
    s_b_valid  = 1'b1;
    rst = 1'b1;
    cyc();
    settle();
    chk("rst_mid_outputs", ctl_outs(), 0);
    rst = 1'b0;
    cyc();
    settle();
    chk("rst_late_b_dropped", ctl_outs(), 0);
    chk("rst_wptr", 64'(dut.wptr), 0);
    s_b_valid = 1'b0;
    wptr_m = 0;
    rptr_m = 0;
    wpend  = '0;
    rpend  = '0;
    do_write(2'b10, 0, 1, 0);
    chk("wptr_after_m1", 64'(dut.wptr), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_lite_arbiter.md
Name: axi_lite_arbiter

Overview:
Shares one downstream AXI-Lite slave between NUM_MASTER upstream AXI-Lite masters. Reads and writes are arbitrated independently, each with round-robin priority. One transaction is outstanding per direction, so responses are routed back without ID tagging. It sits between CPU-side and debug/DMA-side requesters and a shared peripheral bus, normally followed by axi_lite_buf for timing.

Parameters:
NUM_MASTER, 2, number of upstream masters (>=2)
ADDR_WIDTH, 48, address width
DATA_WIDTH, 64, data width; STRB_WIDTH = DATA_WIDTH/8
IDX_WIDTH, $clog2(NUM_MASTER), grant index width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
m_aw_valid/m_aw_ready  in/out  NUM_MASTER  per-master AW handshake
m_aw_addr  in  NUM_MASTER*ADDR_WIDTH  packed, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
m_aw_prot  in  NUM_MASTER*3  packed prot
m_w_valid/m_w_ready  in/out  NUM_MASTER  W handshake
m_w_data  in  NUM_MASTER*DATA_WIDTH; m_w_strb  in  NUM_MASTER*STRB_WIDTH
m_b_valid/m_b_ready  out/in  NUM_MASTER; m_b_resp  out  NUM_MASTER*2
m_ar_valid/m_ar_ready  in/out  NUM_MASTER; m_ar_addr  in  NUM_MASTER*ADDR_WIDTH; m_ar_prot  in  NUM_MASTER*3
m_r_valid/m_r_ready  out/in  NUM_MASTER; m_r_data  out  NUM_MASTER*DATA_WIDTH; m_r_resp  out  NUM_MASTER*2
s_aw_valid/s_aw_ready  out/in  1; s_aw_addr  out  ADDR_WIDTH; s_aw_prot  out  3
s_w_valid/s_w_ready  out/in  1; s_w_data  out  DATA_WIDTH; s_w_strb  out  STRB_WIDTH
s_b_valid/s_b_ready  in/out  1; s_b_resp  in  2
s_ar_valid/s_ar_ready  out/in  1; s_ar_addr  out  ADDR_WIDTH; s_ar_prot  out  3
s_r_valid/s_r_ready  in/out  1; s_r_data  in  DATA_WIDTH; s_r_resp  in  2

Behaviour:
- Clock clk, reset rst: synchronous, active-high. On reset, both FSMs go to IDLE, both rr pointers go to 0, aw_done/w_done clear, and every valid/ready output is 0.
- Write FSM: W_IDLE -> W_ADDR -> W_RESP -> W_IDLE.
- W_IDLE: all write-side outputs are 0. If any m_aw_valid is set, register wgnt = first i with m_aw_valid[i] searching from wptr upward, wrapping modulo NUM_MASTER, then go to W_ADDR. Arbitration uses AW only; a W arriving before its AW waits.
- W_ADDR:
  - s_aw_valid = m_aw_valid[wgnt] & ~aw_done; m_aw_ready[wgnt] = s_aw_ready & ~aw_done.
  - W channel is handled the same way with w_done.
  - Payload muxes select wgnt. Ready outputs to non-granted masters are 0.
  - aw_done/w_done set on their handshakes; both may complete in the same cycle, in either order.
  - Move to W_RESP in the cycle both are done, counting handshakes in the current cycle.
- W_RESP:
  - m_b_valid[wgnt] = s_b_valid; m_b_resp[wgnt] = s_b_resp; s_b_ready = m_b_ready[wgnt].
  - On the B handshake: wptr <= (wgnt+1) mod NUM_MASTER, clear done flags, go to W_IDLE.
- Read FSM: R_IDLE -> R_ADDR -> R_RESP -> R_IDLE, with its own rgnt/rptr.
  - R_ADDR forwards AR from rgnt; the AR handshake moves to R_RESP.
  - R_RESP routes R to rgnt; the R handshake updates rptr and returns to R_IDLE.
- Latency: the first valid from a master reaches the slave exactly 1 cycle later. The return to IDLE costs 1 cycle, so the slave sees at most one new AW/AR every 3 cycles.
- Read and write paths are fully independent; the same or different masters may hold both grants concurrently.
- Non-granted m_b_valid/m_r_valid are 0. Unselected m_b_resp/m_r_resp/m_r_data lanes drive the slave value (don't-care).
- A grant is never revoked before its response completes; a master dropping valid after grant is an AXI violation and is not handled.
- Reset mid-transaction abandons it; slave responses arriving after reset are not forwarded, because s_b_ready/s_r_ready are 0 in IDLE.
- No combinational path from m_*_valid to s_*_ready.

Test Plan:
- Single write: M0 sends AW addr=0x1000, W data=0xDEADBEEF, strb=0xFF; slave returns B resp=0. Required: s_aw_valid is 1 exactly one cycle after m_aw_valid[0]; only m_b_valid[0] is asserted, resp=0; wptr=1.
- Contention: M0 and M1 both raise AR in the same cycle and keep re-requesting (NUM_MASTER=2). Required: grants alternate 0,1,0,1; read data 0x11/0x22 is returned to the correct master only.
- W before AW: M1 presents W 2 cycles before AW; the slave asserts s_aw_ready 3 cycles after s_w_ready. Required: single slave transaction, W completes first, B goes to M1.
- Concurrent read and write: M0 writes while M1 reads with overlapping handshakes. Required: both complete, no cross-routing, B goes to M0 and R to M1.
- Back-pressure: m_b_ready[0] is held low 5 cycles with s_b_valid=1. Required: s_b_ready=0 for 5 cycles; M1's pending AW is not granted until the B handshake completes.
- Reset: assert rst in W_ADDR after the AW handshake, before W. Required: next cycle all outputs are 0 and the FSM is idle; a new M1 write then completes normally starting with wptr=0.
